// File: rtl/perceptron_scheduler.sv
// Round-robin scheduler sharing one perceptron MAC between N_REQ image sources.
// Accepts an image, runs the perceptron until ready, drains its index, returns the class.
module perceptron_scheduler #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned WIDTH     = 25,
  parameter int unsigned TIMEOUT   = 63,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req_valid,
  input  logic [N_REQ*WIDTH-1:0]                    req_data,
  output logic [N_REQ-1:0]                          req_ready,
  output logic [N_REQ-1:0]                          rsp_valid,
  input  logic [N_REQ-1:0]                          rsp_ack,
  output logic [1:0]                                rsp_class,
  output logic                                      rsp_timeout,
  output logic [WIDTH-1:0]                          pe_in,
  output logic                                      pe_en,
  input  logic [1:0]                                pe_out,
  input  logic                                      pe_ready,
  output logic                                      busy,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id
);

  localparam int unsigned GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CMAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

  state_t           state, state_n;
  logic [GW-1:0]    last_grant, last_grant_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N_REQ-1:0] req_ready_n, rsp_valid_n;
  logic [1:0]       rsp_class_n;
  logic             rsp_timeout_n;
  logic [WIDTH-1:0] pe_in_n;
  logic             pe_en_n;
  logic [GW-1:0]    grant_id_n;
  logic             found;
  logic [GW-1:0]    sel;
  logic [GW:0]      cand;

  assign busy = (state != IDLE);

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    cnt_n         = cnt;
    req_ready_n   = '0;
    rsp_valid_n   = rsp_valid;
    rsp_class_n   = rsp_class;
    rsp_timeout_n = rsp_timeout;
    pe_in_n       = pe_in;
    pe_en_n       = 1'b0;
    grant_id_n    = grant_id;
    found         = 1'b0;
    sel           = '0;
    cand          = '0;

    // Round-robin search starting just after the previous grant.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k + 1);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (!found && req_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        sel   = cand[GW-1:0];
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          req_ready_n[sel] = 1'b1;
          pe_in_n          = req_data[sel*WIDTH +: WIDTH];
          grant_id_n       = sel;
          last_grant_n     = sel;
          cnt_n            = '0;
          state_n          = RUN;
        end
      end
      RUN: begin
        pe_en_n = 1'b1;
        // pe_en is registered, so the counter tracks cycles the perceptron actually saw en.
        cnt_n   = cnt + CW'(pe_en);
        if (pe_ready) begin
          rsp_class_n   = pe_out;
          rsp_timeout_n = 1'b0;
          cnt_n         = '0;
          state_n       = DRAIN;
        end else if (cnt == CW'(TIMEOUT)) begin
          rsp_class_n   = 2'b00;
          rsp_timeout_n = 1'b1;
          cnt_n         = '0;
          state_n       = DRAIN;
        end
      end
      DRAIN: begin
        pe_en_n = 1'b1;
        cnt_n   = cnt + CW'(1);
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          pe_en_n               = 1'b0;
          rsp_valid_n           = '0;
          rsp_valid_n[grant_id] = 1'b1;
          state_n               = RESP;
        end
      end
      RESP: begin
        if (rsp_ack[grant_id]) begin
          rsp_valid_n = '0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GW'(N_REQ - 1);
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_class   <= 2'b00;
      rsp_timeout <= 1'b0;
      pe_in       <= '0;
      pe_en       <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      cnt         <= cnt_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_class   <= rsp_class_n;
      rsp_timeout <= rsp_timeout_n;
      pe_in       <= pe_in_n;
      pe_en       <= pe_en_n;
      grant_id    <= grant_id_n;
    end
  end

endmodule

// File: tb/tb_perceptron_scheduler.sv
// Directed bench for perceptron_scheduler with a behavioural perceptron stub
// (ready at en-count 50..51, index wraps after 54 en cycles).
module tb_perceptron_scheduler;

  localparam logic [24:0] CROSS  = 25'h1101011;
  localparam logic [24:0] CIRCLE = 25'h0404404;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [49:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ack = '0;
  logic [1:0]  rsp_class;
  logic        rsp_timeout;
  logic [24:0] pe_in;
  logic        pe_en;
  logic [1:0]  pe_out;
  logic        pe_ready;
  logic        busy;
  logic [0:0]  grant_id;

  logic [5:0]  stub_cnt;
  logic        stub_clr = 1'b1;
  logic        stub_stuck = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  perceptron_scheduler #(.N_REQ(2), .WIDTH(25), .TIMEOUT(63), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_class(rsp_class), .rsp_timeout(rsp_timeout), .pe_in(pe_in),
    .pe_en(pe_en), .pe_out(pe_out), .pe_ready(pe_ready), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (stub_clr) stub_cnt <= '0;
    else if (pe_en) stub_cnt <= (stub_cnt == 6'd53) ? 6'd0 : stub_cnt + 6'd1;
  end
  assign pe_ready = !stub_stuck && (stub_cnt == 6'd50 || stub_cnt == 6'd51);
  assign pe_out = !pe_ready ? 2'b00 :
                  (pe_in == CROSS)  ? 2'b11 :
                  (pe_in == CIRCLE) ? 2'b10 : 2'b01;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   req_ready,   0);
    check({tag, "_rsp_valid"},   rsp_valid,   0);
    check({tag, "_rsp_class"},   rsp_class,   0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_pe_en"},       pe_en,       0);
    check({tag, "_pe_in"},       pe_in,       0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_grant_id"},    grant_id,    0);
  endtask

  task automatic wait_accept(input int r, output int t0);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (req_ready != 2'b00) got = 1'b1;
    end
    check("accept_seen", got, 1);
    t0 = cyc;
    check("req_ready", req_ready, 64'(2'b01 << r));
    check("grant_id", grant_id, r);
  endtask

  task automatic wait_rsp(input int t0, input int r, input logic [24:0] img,
                          input logic [1:0] cls, input logic to, input int lat);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (rsp_valid != 2'b00) got = 1'b1;
    end
    check("rsp_seen", got, 1);
    check("rsp_latency", cyc - t0, lat);
    check("rsp_valid", rsp_valid, 64'(2'b01 << r));
    check("rsp_class", rsp_class, cls);
    check("rsp_timeout", rsp_timeout, to);
    check("pe_in_held", pe_in, img);
    check("pe_en_resp", pe_en, 0);
    if (!to) check("pe_index_wrapped", stub_cnt, 0);
  endtask

  task automatic do_ack(input int r);
    rsp_ack = '0;
    rsp_ack[r] = 1'b1;
    step();
    rsp_ack = '0;
    check("ack_rsp_valid", rsp_valid, 0);
    check("ack_idle", busy, 0);
  endtask

  task automatic run_job(input int r, input logic [24:0] img, input logic [1:0] cls,
                         input logic to, input int lat);
    int t0;
    req_valid[r] = 1'b1;
    req_data[r*25 +: 25] = img;
    wait_accept(r, t0);
    req_valid[r] = 1'b0;
    req_data[r*25 +: 25] = 25'h1ffffff;
    wait_rsp(t0, r, img, cls, to, lat);
    do_ack(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    bit stable;

    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    stub_clr = 1'b0;
    step();

    run_job(0, CROSS, 2'b11, 1'b0, 55);
    run_job(1, CIRCLE, 2'b10, 1'b0, 55);
    run_job(1, '0, 2'b01, 1'b0, 55);

    req_data = {CIRCLE, CROSS};
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_accept(j % 2, t0);
      wait_rsp(t0, j % 2, (j % 2 == 0) ? CROSS : CIRCLE,
               (j % 2 == 0) ? 2'b11 : 2'b10, 1'b0, 55);
      do_ack(j % 2);
    end
    req_valid = '0;

    req_valid[0] = 1'b1;
    req_data[24:0] = CROSS;
    wait_accept(0, t0);
    req_valid = '0;
    wait_rsp(t0, 0, CROSS, 2'b11, 1'b0, 55);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid != 2'b01 || rsp_class != 2'b11 || !busy) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    rsp_ack = 2'b10;
    step();
    rsp_ack = '0;
    check("other_ack_ignored", rsp_valid, 2'b01);
    check("other_ack_class", rsp_class, 2'b11);
    do_ack(0);

    stub_stuck = 1'b1;
    run_job(1, CROSS, 2'b00, 1'b1, 68);
    stub_stuck = 1'b0;
    stub_clr = 1'b1;
    step();
    stub_clr = 1'b0;

    req_valid[0] = 1'b1;
    req_data[24:0] = CROSS;
    wait_accept(0, t0);
    req_valid = '0;
    repeat (20) step();
    check("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    stub_clr = 1'b1;
    step();
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    stub_clr = 1'b0;

    // last_grant was 0 before reset; a reset must make requester 0 win again.
    req_data = {CIRCLE, CROSS};
    req_valid = 2'b11;
    wait_accept(0, t0);
    req_valid = '0;
    wait_rsp(t0, 0, CROSS, 2'b11, 1'b0, 55);
    do_ack(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_scheduler.md
# perceptron_scheduler

Shares one `perceptron` MAC instance (WIDTH=25 pixel inputs, 2-bit class output) between N_REQ independent image sources. Sources are served round-robin: the scheduler accepts a 5x5 binary image, drives the perceptron's `in`/`en`, and waits for `ready`. It then captures the class code, lets the perceptron's index counter wrap back to zero, and returns the result to the requester over a valid/ack handshake. A watchdog reports a timeout if the perceptron never asserts `ready`.

## Interface
Parameters:
- N_REQ, 2, number of requesters (≥1)
- WIDTH, 25, image width in bits; must match the perceptron instance
- TIMEOUT, 63, maximum RUN cycles before the job is aborted; must exceed 2*WIDTH
- DRAIN_CYC, 3, `en`-high cycles after `ready` that return the perceptron index to 0

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  bit i: requester i has an image pending
- req_data  in  N_REQ*WIDTH  image of requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse
- rsp_valid  out  N_REQ  one-hot, result available for requester i
- rsp_ack  in  N_REQ  requester i consumes its result
- rsp_class  out  2  class of the current result: 10 circle, 11 cross, 01 unknown, 00 timeout
- rsp_timeout  out  1  current result was aborted by the watchdog
- pe_in  out  WIDTH  image to the perceptron `in`
- pe_en  out  1  perceptron `en`
- pe_out  in  2  perceptron `out`
- pe_ready  in  1  perceptron `ready`
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(N_REQ) (min 1)  index of the requester being served

## Operation
- States: IDLE, RUN, DRAIN, RESP.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise grant the first set `req_valid` bit, searching upward from (last_grant+1) mod N_REQ.
  - Pulse `req_ready[g]`, latch the image slice into `pe_in`, load `grant_id`=g and last_grant=g, clear the cycle counter, go to RUN.
- RUN:
  - `pe_en`=1; the cycle counter increments each cycle.
  - If `pe_ready`=1: capture `pe_out` into the class register, clear the timeout flag, go to DRAIN. This check has priority over the timeout check.
  - Else if counter==TIMEOUT: class=00, timeout flag=1, go to DRAIN.
- DRAIN:
  - `pe_en`=1 for exactly DRAIN_CYC cycles, counted with the same counter after clearing it, then go to RESP.
  - The DRAIN_CYC default of 3 comes from the perceptron behaviour: `ready` holds for 2 cycles at index WIDTH, and the index wraps on the next cycle.
- RESP:
  - `pe_en`=0; `rsp_valid[grant_id]`=1; `rsp_class` and `rsp_timeout` are held stable.
  - When `rsp_ack[grant_id]`=1, drop `rsp_valid` and go to IDLE.
  - `rsp_ack` bits of other requesters are ignored.
- `pe_in` holds its value from the accept cycle until the next accept; requesters may change `req_data` after their `req_ready` pulse.
- `req_valid` changes while the scheduler is not in IDLE are ignored. A requester that drops `req_valid` before it is granted is simply skipped.
- Reset, from any state including mid-RUN:
  - state=IDLE, last_grant=N_REQ-1 (so requester 0 wins the first arbitration).
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_class`, `rsp_timeout`, `pe_en`, `pe_in`, `busy`, `grant_id`.
  - The perceptron has no reset port. Its reset alignment relies on its own initialisation; the scheduler does not re-drive it.

## Timing
- Accept at cycle T (IDLE, `req_ready` high); RUN from T+1 with `pe_en`=1.
- With the WIDTH=25 perceptron, `pe_ready` rises after 2*WIDTH=50 `en` cycles and is sampled at T+51.
- DRAIN occupies T+52..T+54; `rsp_valid` is high from T+55.
- A timeout job reaches RESP at T+1+TIMEOUT+1+DRAIN_CYC.
- An ack at cycle A puts the scheduler in IDLE at A+1; the next accept happens at A+1 at the earliest. There is no back-to-back overlap.
- All outputs are registered except `busy`, which decodes state combinationally.

## Test plan
- Reset, then a cross image on requester 0 (bits 0,4,12,20,24 set) -> `req_ready`=01 at T, `rsp_valid`=01 at T+55, `rsp_class`=11, `rsp_timeout`=0.
- Circle image (bits 2,10,14,22 set) on requester 1 -> `rsp_class`=10; an all-zero image -> 01.
- Both requesters valid continuously for 4 jobs, each acked immediately -> grants alternate 0,1,0,1.
- Hold `rsp_ack`=0 for 20 cycles, pulse `rsp_ack` on the non-granted bit, then ack the granted bit -> `rsp_valid` and `rsp_class` stay stable throughout, and the scheduler reaches IDLE one cycle after the correct ack.
- Tie `pe_ready` to 0 in a stub -> `rsp_class`=00, `rsp_timeout`=1, `rsp_valid` at T+1+63+1+3.
- Assert `rst_n`=0 during RUN at T+20 -> the next cycle shows all outputs 0 and state IDLE, and a fresh request is accepted for requester 0.
